// File: rtl/timer_pkg.sv
// Shared state encodings and defaults for the keypad cooking timer controller.
package timer_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SETUP   = 3'd1,
      COOKING = 3'd2,
      PAUSED  = 3'd3,
      DONE    = 3'd4
   } state_t;

   localparam int unsigned BEEP_TICKS_DEFAULT = 3;
   localparam int unsigned DIGIT_MAX          = 9;

endpackage

// File: rtl/timer_control_if.sv
// Keypad/door/tick inputs and counter-chain/status outputs of timer_control.
interface timer_control_if;
   import timer_pkg::*;

   logic        key_valid;
   logic [3:0]  key_digit;
   logic        start;
   logic        stop_clear;
   logic        door_open;
   logic        sec_tick;
   logic        timer_zero;
   logic [15:0] entry;
   logic        load;
   logic        enablen;
   logic        cook_on;
   logic        alarm;
   logic [2:0]  state_out;

   modport master (
      output key_valid, key_digit, start, stop_clear, door_open, sec_tick, timer_zero,
      input  entry, load, enablen, cook_on, alarm, state_out
   );

   modport slave (
      input  key_valid, key_digit, start, stop_clear, door_open, sec_tick, timer_zero,
      output entry, load, enablen, cook_on, alarm, state_out
   );

endinterface

// File: rtl/bcd_entry_reg.sv
// Four-digit BCD entry shift register; new digits enter at the seconds-units end.
module bcd_entry_reg
   import timer_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        shift,
   input  logic        clear,
   input  logic [3:0]  digit,
   output logic        digit_ok,
   output logic [15:0] entry
);

   assign digit_ok = (digit <= 4'(DIGIT_MAX));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         entry <= '0;
      end else if (clear) begin
         entry <= '0;
      end else if (shift && digit_ok) begin
         entry <= {entry[11:0], digit};
      end
   end

endmodule

// File: rtl/timer_control.sv
// Cooking timer controller: keypad entry, start/pause/clear sequencing, alarm beeps.
module timer_control
   import timer_pkg::*;
#(
   parameter int unsigned BEEP_TICKS = BEEP_TICKS_DEFAULT
) (
   input logic            clk,
   input logic            rst,
   timer_control_if.slave tif
);

   localparam int unsigned BW = (BEEP_TICKS < 1) ? 1 : $clog2(BEEP_TICKS + 1);

   state_t        state, state_n;
   logic          load_q, enablen_q;
   logic          load_req, en_req, shift_req, clear_req;
   logic [BW-1:0] beep_cnt;
   logic          beep_last;
   logic [15:0]   entry;
   logic          digit_ok;
   logic          entry_zero;
   logic          key_ok;

   bcd_entry_reg u_entry (
      .clk      (clk),
      .rst      (rst),
      .shift    (shift_req),
      .clear    (clear_req),
      .digit    (tif.key_digit),
      .digit_ok (digit_ok),
      .entry    (entry)
   );

   assign entry_zero = (entry == '0);
   assign key_ok     = tif.key_valid && digit_ok;
   assign beep_last  = (beep_cnt == BW'(BEEP_TICKS - 1));

   // Beep counter idles at zero outside DONE, so it is always clear on entry.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         load_q    <= 1'b0;
         enablen_q <= 1'b1;
         beep_cnt  <= '0;
      end else begin
         state     <= state_n;
         load_q    <= load_req;
         enablen_q <= ~en_req;
         if (state != DONE) begin
            beep_cnt <= '0;
         end else if (tif.sec_tick) begin
            beep_cnt <= beep_cnt + BW'(1);
         end
      end
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (!tif.stop_clear && !tif.start && key_ok) state_n = SETUP;
         SETUP:   if (tif.stop_clear) state_n = IDLE;
                  else if (tif.start && !tif.door_open && !entry_zero) state_n = COOKING;
         COOKING: if (tif.stop_clear || tif.door_open) state_n = PAUSED;
                  else if (tif.sec_tick && tif.timer_zero) state_n = DONE;
         PAUSED:  if (tif.stop_clear) state_n = IDLE;
                  else if (tif.start && !tif.door_open) state_n = COOKING;
         DONE:    if (tif.stop_clear || (tif.sec_tick && beep_last)) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      load_req  = 1'b0;
      en_req    = 1'b0;
      shift_req = 1'b0;
      clear_req = 1'b0;
      case (state)
         IDLE: begin
            shift_req = !tif.stop_clear && !tif.start && tif.key_valid;
            clear_req = tif.stop_clear;
         end
         SETUP: begin
            shift_req = !tif.stop_clear && !tif.start && tif.key_valid;
            clear_req = tif.stop_clear;
            load_req  = !tif.stop_clear && tif.start && !tif.door_open && !entry_zero;
         end
         COOKING: en_req = !tif.stop_clear && !tif.door_open && tif.sec_tick && !tif.timer_zero;
         PAUSED: begin
            clear_req = tif.stop_clear;
            load_req  = tif.stop_clear;
         end
         DONE:    clear_req = tif.stop_clear || (tif.sec_tick && beep_last);
         default: ;
      endcase
   end

   assign tif.entry     = entry;
   assign tif.load      = load_q;
   assign tif.enablen   = enablen_q;
   assign tif.cook_on   = (state == COOKING);
   assign tif.alarm     = (state == DONE);
   assign tif.state_out = state;

endmodule

// File: tb/tb_timer_control.sv
// Directed plus randomized bench for timer_control against a decimal-arithmetic reference model.
module tb_timer_control;

   logic clk = 1'b0;
   logic rst;

   timer_control_if tif ();

   timer_control #(.BEEP_TICKS(3)) dut (
      .clk (clk),
      .rst (rst),
      .tif (tif)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: entry kept as a decimal number 0..9999, states as plain codes.
   int m_state;
   int m_num;
   int m_beeps;
   bit m_load;
   bit m_en_n;

   function automatic logic [15:0] to_bcd(input int n);
      return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
   endfunction

   task automatic model_reset();
      m_state = 0; m_num = 0; m_beeps = 0; m_load = 0; m_en_n = 1;
   endtask

   task automatic model_step(input bit kv, input int d, input bit st, input bit sc,
                             input bit door, input bit tick, input bit tz);
      m_load = 0;
      m_en_n = 1;
      if (m_state == 0) begin
         if (!sc && !st && kv && d <= 9) begin
            m_num = (m_num * 10 + d) % 10000;
            m_state = 1;
         end
      end else if (m_state == 1) begin
         if (sc) begin
            m_num = 0; m_state = 0;
         end else if (st) begin
            if (!door && m_num != 0) begin
               m_load = 1; m_state = 2;
            end
         end else if (kv && d <= 9) begin
            m_num = (m_num * 10 + d) % 10000;
         end
      end else if (m_state == 2) begin
         if (sc || door) m_state = 3;
         else if (tick && tz) begin
            m_state = 4; m_beeps = 0;
         end else if (tick) m_en_n = 0;
      end else if (m_state == 3) begin
         if (sc) begin
            m_num = 0; m_load = 1; m_state = 0;
         end else if (st && !door) m_state = 2;
      end else begin
         if (sc) begin
            m_num = 0; m_state = 0;
         end else if (tick) begin
            m_beeps++;
            if (m_beeps == 3) begin
               m_num = 0; m_state = 0;
            end
         end
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_model(input string tag);
      logic [31:0] obs, exp;
      obs = {9'd0, tif.state_out, tif.entry, tif.load, tif.enablen, tif.cook_on, tif.alarm};
      exp = {9'd0, 3'(m_state), to_bcd(m_num), m_load, m_en_n, m_state == 2, m_state == 4};
      check(tag, obs, exp);
   endtask

   task automatic step(input bit kv, input int d, input bit st, input bit sc,
                       input bit door, input bit tick, input bit tz, input string tag);
      tif.key_valid  = kv;
      tif.key_digit  = 4'(d);
      tif.start      = st;
      tif.stop_clear = sc;
      tif.door_open  = door;
      tif.sec_tick   = tick;
      tif.timer_zero = tz;
      model_step(kv, d, st, sc, door, tick, tz);
      @(posedge clk);
      #1;
      check_model(tag);
   endtask

   task automatic key(input int d);
      step(1, d, 0, 0, 0, 0, 0, "key");
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, "idle");
   endtask

   task automatic async_reset(input string tag);
      #2 rst = 1'b0;
      model_reset();
      #1 check_model(tag);
      #2 rst = 1'b1;
   endtask

   initial begin
      rst = 1'b0;
      tif.key_valid = 0; tif.key_digit = 0; tif.start = 0; tif.stop_clear = 0;
      tif.door_open = 0; tif.sec_tick = 0; tif.timer_zero = 0;
      model_reset();
      @(posedge clk);
      #1;
      check_model("reset_state");
      check("reset_enablen", 32'(tif.enablen), 32'd1);
      rst = 1'b1;
      idle(2);

      // Keys 1,3,0 then start
      key(1); key(3); key(0);
      step(0, 0, 1, 0, 0, 0, 0, "start");
      check("req039_entry", 32'(tif.entry), 32'h0130);
      check("req039_load", 32'(tif.load), 32'd1);
      check("req039_cook", 32'(tif.cook_on), 32'd1);
      idle(1);
      check("req039_load_once", 32'(tif.load), 32'd0);

      // Enable pulse one cycle after each tick, then finish
      for (int t = 0; t < 3; t++) begin
         idle(9);
         step(0, 0, 0, 0, 0, 1, 0, "tick");
         check("req040_en_low", 32'(tif.enablen), 32'd0);
         idle(1);
         check("req040_en_high", 32'(tif.enablen), 32'd1);
      end
      idle(5);
      step(0, 0, 0, 0, 0, 1, 1, "tick_zero");
      check("req040_done", 32'(tif.state_out), 32'd4);
      check("req040_alarm", 32'(tif.alarm), 32'd1);

      // Beep count, then early stop
      for (int t = 0; t < 3; t++) begin
         idle(4);
         step(0, 0, 0, 0, 0, 1, 0, "beep");
         if (t == 1) check("req041_still_done", 32'(tif.alarm), 32'd1);
      end
      check("req041_idle", 32'(tif.state_out), 32'd0);
      check("req041_entry", 32'(tif.entry), 32'd0);
      key(5);
      step(0, 0, 1, 0, 0, 0, 0, "start");
      step(0, 0, 0, 0, 0, 1, 1, "tick_zero");
      idle(1);
      step(0, 0, 0, 0, 0, 1, 0, "beep");
      step(0, 0, 0, 1, 0, 0, 0, "stop_done");
      check("req041_stop_idle", 32'(tif.state_out), 32'd0);
      check("req041_stop_alarm", 32'(tif.alarm), 32'd0);

      // Door open with coincident tick, resume without load
      key(2);
      step(0, 0, 1, 0, 0, 0, 0, "start");
      idle(2);
      step(0, 0, 0, 0, 1, 1, 0, "door_tick");
      check("req042_paused", 32'(tif.state_out), 32'd3);
      check("req042_no_en", 32'(tif.enablen), 32'd1);
      step(0, 0, 1, 0, 1, 0, 0, "start_door_open");
      step(0, 0, 1, 0, 0, 0, 0, "resume");
      check("req042_cooking", 32'(tif.state_out), 32'd2);
      check("req042_no_load", 32'(tif.load), 32'd0);

      // Pause then clear
      step(0, 0, 0, 1, 0, 0, 0, "stop_cook");
      step(0, 0, 0, 1, 0, 0, 0, "clear_paused");
      check("req026_load", 32'(tif.load), 32'd1);
      check("req026_entry", 32'(tif.entry), 32'd0);

      // Overflowing entry, invalid digit, start with door open
      key(1); key(2); key(3); key(4); key(5); key(12);
      step(0, 0, 1, 0, 1, 0, 0, "start_door");
      check("req043_entry", 32'(tif.entry), 32'h2345);
      check("req043_setup", 32'(tif.state_out), 32'd1);
      step(1, 7, 1, 1, 0, 0, 0, "stop_start");
      check("req043_idle", 32'(tif.state_out), 32'd0);
      check("req043_clear", 32'(tif.entry), 32'd0);
      step(0, 0, 1, 0, 0, 0, 0, "start_idle");

      // Reset mid-cooking and mid-load
      key(9);
      step(0, 0, 1, 0, 0, 0, 0, "start");
      idle(3);
      step(0, 0, 0, 0, 0, 1, 0, "tick");
      async_reset("req044_mid_cook");
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, (i == 1), 0, "post_reset");
      key(7);
      step(0, 0, 1, 0, 0, 0, 0, "start");
      async_reset("req035_mid_load");
      idle(3);

      // Randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         bit kv, st, sc, door, tick, tz;
         int d;
         kv   = ($urandom_range(0, 99) < 40);
         d    = $urandom_range(0, 15);
         st   = ($urandom_range(0, 99) < 15);
         sc   = ($urandom_range(0, 99) < 4);
         door = ($urandom_range(0, 99) < 12);
         tick = ($urandom_range(0, 99) < 25);
         tz   = ($urandom_range(0, 99) < 15);
         step(kv, d, st, sc, door, tick, tz, "random");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
